// File: rtl/vram_arb_if.sv
// vram_arb_if: host port and renderer-channel bundle for the banked video RAM
interface vram_arb_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int N_CH = 3,
  parameter int CNT_W = 16
);
  logic host_en;
  logic host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic [DATA_W-1:0] host_dout;
  logic host_rvalid;
  logic [N_CH-1:0] ch_req;
  logic [N_CH-1:0] ch_we;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*DATA_W-1:0] ch_din;
  logic [N_CH-1:0] ch_gnt;
  logic [N_CH-1:0] ch_rvalid;
  logic [N_CH*DATA_W-1:0] ch_dout;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output host_en, host_we, host_addr, host_din, ch_req, ch_we, ch_addr, ch_din,
    input host_dout, host_rvalid, ch_gnt, ch_rvalid, ch_dout, stall_cnt
  );
  modport slave (
    input host_en, host_we, host_addr, host_din, ch_req, ch_we, ch_addr, ch_din,
    output host_dout, host_rvalid, ch_gnt, ch_rvalid, ch_dout, stall_cnt
  );
endinterface

// File: rtl/vram_arb.sv
// vram_arb: banked dual-port video RAM, host on port A, round-robin renderer channels on port B
module vram_arb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int BANK_W = 2,
  parameter int N_CH = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  vram_arb_if.slave bus
);
  localparam int IDX_W = ADDR_W - BANK_W;
  localparam int NB = 1 << BANK_W;
  localparam int BS_W = BANK_W > 0 ? BANK_W : 1;
  localparam int RR_W = N_CH > 1 ? $clog2(N_CH) : 1;
  function automatic logic [BS_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return BS_W'(a >> IDX_W);
  endfunction
  logic he, hw;
  logic [BS_W-1:0] host_bank, host_bank_q;
  logic [IDX_W-1:0] host_idx;
  logic [N_CH-1:0][BS_W-1:0] ch_bank, ch_bank_q;
  logic [N_CH-1:0] hit, cand, gnt;
  logic [NB-1:0][RR_W-1:0] rr, win;
  logic [NB-1:0] win_v, pb_we;
  logic [NB-1:0][IDX_W-1:0] pb_idx;
  logic [NB-1:0][DATA_W-1:0] pb_din, q_a, q_b;
  logic [CNT_W-1:0] stall;
  assign he = bus.host_en & ~rst;
  assign hw = he & bus.host_we;
  assign host_bank = bank_of(bus.host_addr);
  assign host_idx = bus.host_addr[IDX_W-1:0];
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ch_bank[c] = bank_of(bus.ch_addr[c*ADDR_W +: ADDR_W]);
    assign hit[c] = ch_bank[c] == host_bank;
    assign bus.ch_dout[c*DATA_W +: DATA_W] = q_b[ch_bank_q[c]];
  end
  assign cand = bus.ch_req & ~(bus.ch_we & hit & {N_CH{hw}}) & {N_CH{~rst}};
  always_comb begin
    logic [RR_W-1:0] lo, hi;
    logic lo_v, hi_v;
    gnt = '0;
    win = '0;
    win_v = '0;
    pb_we = '0;
    pb_idx = '0;
    pb_din = '0;
    for (int b = 0; b < NB; b++) begin
      lo = '0;
      hi = '0;
      lo_v = 1'b0;
      hi_v = 1'b0;
      for (int c = N_CH - 1; c >= 0; c--) begin
        if (cand[c] && ch_bank[c] == BS_W'(b)) begin
          lo = RR_W'(c);
          lo_v = 1'b1;
          if (RR_W'(c) >= rr[b]) begin
            hi = RR_W'(c);
            hi_v = 1'b1;
          end
        end
      end
      win_v[b] = lo_v;
      win[b] = hi_v ? hi : lo;
      for (int c = 0; c < N_CH; c++) begin
        if (win_v[b] && win[b] == RR_W'(c)) begin
          gnt[c] = 1'b1;
          pb_we[b] = bus.ch_we[c];
          pb_idx[b] = bus.ch_addr[c*ADDR_W +: IDX_W];
          pb_din[b] = bus.ch_din[c*DATA_W +: DATA_W];
        end
      end
    end
  end
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_W-1:0] mem [1 << IDX_W];
    logic [DATA_W-1:0] qa, qb;
    always_ff @(posedge clk) begin
      if (he && host_bank == BS_W'(b)) begin
        if (bus.host_we) mem[host_idx] <= bus.host_din;
        qa <= mem[host_idx];
      end
      if (win_v[b]) begin
        if (pb_we[b]) mem[pb_idx[b]] <= pb_din[b];
        qb <= mem[pb_idx[b]];
      end
    end
    assign q_a[b] = qa;
    assign q_b[b] = qb;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.host_rvalid <= 1'b0;
      bus.ch_rvalid <= '0;
      host_bank_q <= '0;
      ch_bank_q <= '0;
      rr <= '0;
      stall <= '0;
    end else begin
      bus.host_rvalid <= bus.host_en & ~bus.host_we;
      if (bus.host_en) host_bank_q <= host_bank;
      bus.ch_rvalid <= gnt & ~bus.ch_we;
      for (int c = 0; c < N_CH; c++)
        if (gnt[c] && !bus.ch_we[c]) ch_bank_q[c] <= ch_bank[c];
      for (int b = 0; b < NB; b++)
        if (win_v[b]) rr[b] <= win[b] == RR_W'(N_CH - 1) ? '0 : win[b] + RR_W'(1);
      if (|(bus.ch_req & ~gnt) && !(&stall)) stall <= stall + CNT_W'(1);
    end
  end
  assign bus.host_dout = q_a[host_bank_q];
  assign bus.ch_gnt = gnt;
  assign bus.stall_cnt = stall;
endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: vector table, directed sequences and randomized model check for vram_arb
module tb_vram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vram_arb_if #(.ADDR_W(14), .DATA_W(32), .N_CH(3), .CNT_W(4)) bus ();
  vram_arb #(.ADDR_W(14), .DATA_W(32), .BANK_W(2), .N_CH(3), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic h_en, h_we;
  logic [13:0] h_addr;
  logic [31:0] h_din;
  logic [2:0] req, we;
  logic [13:0] addr [3];
  logic [31:0] din [3];
  assign bus.host_en = h_en;
  assign bus.host_we = h_we;
  assign bus.host_addr = h_addr;
  assign bus.host_din = h_din;
  assign bus.ch_req = req;
  assign bus.ch_we = we;
  assign bus.ch_addr = {addr[2], addr[1], addr[0]};
  assign bus.ch_din = {din[2], din[1], din[0]};
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_mem [16384];
  bit m_known [16384];
  int m_rr [4];
  int m_stall = 0;
  bit live = 0;
  logic [2:0] m_gnt;
  logic e_hrv, e_hk;
  logic [31:0] e_hd;
  logic [2:0] e_crv, e_ck;
  logic [31:0] e_cd [3];
  logic [2:0] s_gnt, s_crv;
  logic s_hrv;
  logic [31:0] s_hd;
  logic [31:0] s_cd [3];
  logic [3:0] s_stall;
  typedef struct {
    logic [2:0] req, we;
    logic [13:0] a0, a1, a2;
    logic h_en, h_we;
    logic [13:0] h_addr;
    logic [2:0] gnt;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  function automatic int bk(input logic [13:0] a);
    return int'(a[13:12]);
  endfunction
  function automatic logic [2:0] model_gnt();
    logic [2:0] g = '0;
    if (rst) return g;
    for (int b = 0; b < 4; b++) begin
      int best = -1;
      int bd = 99;
      for (int c = 0; c < 3; c++)
        if (req[c] && bk(addr[c]) == b && !(we[c] && h_en && h_we && bk(h_addr) == b))
          if ((c - m_rr[b] + 3) % 3 < bd) begin
            bd = (c - m_rr[b] + 3) % 3;
            best = c;
          end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction
  task automatic commit(input logic [2:0] g);
    live = 1;
    if (rst) begin
      for (int b = 0; b < 4; b++) m_rr[b] = 0;
      m_stall = 0;
      e_hrv = 0;
      e_crv = '0;
      return;
    end
    e_hrv = h_en && !h_we;
    e_hd = m_mem[h_addr];
    e_hk = m_known[h_addr];
    for (int c = 0; c < 3; c++) begin
      e_crv[c] = g[c] && !we[c];
      e_cd[c] = m_mem[addr[c]];
      e_ck[c] = m_known[addr[c]];
    end
    if (h_en && h_we) begin
      m_mem[h_addr] = h_din;
      m_known[h_addr] = 1;
    end
    for (int c = 0; c < 3; c++)
      if (g[c]) begin
        if (we[c]) begin
          m_mem[addr[c]] = din[c];
          m_known[addr[c]] = 1;
        end
        m_rr[bk(addr[c])] = (c + 1) % 3;
      end
    if ((req & ~g) != 0) m_stall = m_stall == 15 ? 15 : m_stall + 1;
  endtask
  task automatic cyc();
    @(negedge clk);
    m_gnt = model_gnt();
    s_gnt = bus.ch_gnt;
    s_hrv = bus.host_rvalid;
    s_hd = bus.host_dout;
    s_crv = bus.ch_rvalid;
    for (int c = 0; c < 3; c++) s_cd[c] = bus.ch_dout[c*32 +: 32];
    s_stall = bus.stall_cnt;
    if (live) begin
      chk("gnt", {61'd0, s_gnt}, {61'd0, m_gnt});
      chk("host_rvalid", {63'd0, s_hrv}, {63'd0, e_hrv});
      if (e_hrv && e_hk) chk("host_dout", {32'd0, s_hd}, {32'd0, e_hd});
      chk("ch_rvalid", {61'd0, s_crv}, {61'd0, e_crv});
      for (int c = 0; c < 3; c++)
        if (e_crv[c] && e_ck[c]) chk("ch_dout", {32'd0, s_cd[c]}, {32'd0, e_cd[c]});
      chk("stall_cnt", {60'd0, s_stall}, 64'(m_stall));
    end
    @(posedge clk);
    commit(m_gnt);
    #1;
  endtask
  task automatic idle();
    h_en = 0;
    h_we = 0;
    h_addr = '0;
    h_din = '0;
    req = '0;
    we = '0;
    for (int c = 0; c < 3; c++) begin
      addr[c] = '0;
      din[c] = '0;
    end
  endtask
  task automatic host(input logic w, input logic [13:0] a, input logic [31:0] d);
    h_en = 1;
    h_we = w;
    h_addr = a;
    h_din = d;
  endtask
  task automatic chan(input int c, input logic w, input logic [13:0] a, input logic [31:0] d);
    req[c] = 1;
    we[c] = w;
    addr[c] = a;
    din[c] = d;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask
  function automatic logic [13:0] pool(input int i);
    return 14'(((i >> 2) << 12) | 32'h100 | (i & 3));
  endfunction
  initial begin
    tbl[0] = '{3'b111, 3'b000, 14'h0010, 14'h1010, 14'h2010, 0, 0, 14'h0000, 3'b111};
    tbl[1] = '{3'b111, 3'b000, 14'h1001, 14'h1002, 14'h1003, 0, 0, 14'h0000, 3'b001};
    tbl[2] = '{3'b110, 3'b000, 14'h0000, 14'h3001, 14'h3002, 0, 0, 14'h0000, 3'b010};
    tbl[3] = '{3'b001, 3'b001, 14'h1000, 14'h0000, 14'h0000, 1, 1, 14'h1fff, 3'b000};
    tbl[4] = '{3'b011, 3'b001, 14'h1000, 14'h1001, 14'h0000, 1, 1, 14'h1fff, 3'b010};
    tbl[5] = '{3'b001, 3'b001, 14'h2000, 14'h0000, 14'h0000, 1, 1, 14'h1fff, 3'b001};
    tbl[6] = '{3'b100, 3'b000, 14'h0000, 14'h0000, 14'h0003, 1, 1, 14'h0004, 3'b100};
    tbl[7] = '{3'b001, 3'b001, 14'h0030, 14'h0000, 14'h0000, 1, 0, 14'h0030, 3'b001};
    tbl[8] = '{3'b000, 3'b111, 14'h0000, 14'h1000, 14'h2000, 1, 0, 14'h0000, 3'b000};
    tbl[9] = '{3'b101, 3'b101, 14'h3000, 14'h0000, 14'h3001, 0, 0, 14'h0000, 3'b001};
    for (int b = 0; b < 4; b++) m_rr[b] = 0;
    e_hrv = 0;
    e_crv = '0;
    idle();
    do_reset();
    do_reset();
    chk("rst_hrv", {63'd0, s_hrv}, 64'd0);
    chk("rst_crv", {61'd0, s_crv}, 64'd0);
    chk("rst_stall", {60'd0, s_stall}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      do_reset();
      req = tbl[i].req;
      we = tbl[i].we;
      addr[0] = tbl[i].a0;
      addr[1] = tbl[i].a1;
      addr[2] = tbl[i].a2;
      for (int c = 0; c < 3; c++) din[c] = 32'hc0de0000 + 32'(i * 4 + c);
      h_en = tbl[i].h_en;
      h_we = tbl[i].h_we;
      h_addr = tbl[i].h_addr;
      h_din = 32'hface0000 + 32'(i);
      cyc();
      chk("tbl_gnt", {61'd0, s_gnt}, {61'd0, tbl[i].gnt});
    end
    do_reset();
    host(1, 14'h0005, 32'hdeadbeef);
    cyc();
    host(1, 14'h3005, 32'h12345678);
    cyc();
    host(0, 14'h0005, 0);
    cyc();
    host(0, 14'h3005, 0);
    cyc();
    chk("rt_hrv0", {63'd0, s_hrv}, 64'd1);
    chk("rt_dout0", {32'd0, s_hd}, 64'hdeadbeef);
    idle();
    cyc();
    chk("rt_hrv1", {63'd0, s_hrv}, 64'd1);
    chk("rt_dout1", {32'd0, s_hd}, 64'h12345678);
    cyc();
    chk("rt_hrv_end", {63'd0, s_hrv}, 64'd0);
    do_reset();
    chan(0, 0, 14'h0005, 0);
    chan(1, 0, 14'h1010, 0);
    chan(2, 0, 14'h2010, 0);
    cyc();
    chk("par_gnt", {61'd0, s_gnt}, 64'd7);
    idle();
    cyc();
    chk("par_rv", {61'd0, s_crv}, 64'd7);
    chk("par_d0", {32'd0, s_cd[0]}, 64'hdeadbeef);
    chk("par_stall", {60'd0, s_stall}, 64'd0);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < 3; c++) chan(c, 0, 14'(32'h1001 + c), 0);
      cyc();
      chk("rr_seq", {61'd0, s_gnt}, 64'(1 << (i % 3)));
    end
    idle();
    cyc();
    chk("rr_stall", {60'd0, s_stall}, 64'd9);
    do_reset();
    host(1, 14'h1010, 32'haaaa0000);
    chan(1, 1, 14'h1011, 32'h5555);
    cyc();
    chk("haz_gnt0", {61'd0, s_gnt}, 64'd0);
    h_en = 0;
    h_we = 0;
    cyc();
    chk("haz_gnt1", {61'd0, s_gnt}, 64'd2);
    idle();
    host(0, 14'h1010, 0);
    cyc();
    host(0, 14'h1011, 0);
    cyc();
    chk("haz_d0", {32'd0, s_hd}, 64'haaaa0000);
    idle();
    cyc();
    chk("haz_d1", {32'd0, s_hd}, 64'h5555);
    host(1, 14'h0020, 32'h1);
    cyc();
    host(1, 14'h0020, 32'h2);
    chan(0, 0, 14'h0020, 0);
    cyc();
    h_en = 0;
    h_we = 0;
    cyc();
    chk("rf_rv", {63'd0, s_crv[0]}, 64'd1);
    chk("rf_old", {32'd0, s_cd[0]}, 64'h1);
    idle();
    cyc();
    chk("rf_new", {32'd0, s_cd[0]}, 64'h2);
    host(1, 14'h2222, 32'h77);
    cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) chan(c, 0, 14'(32'h2001 + c), 0);
      cyc();
    end
    idle();
    chan(2, 1, 14'h2222, 32'hbeef);
    chan(0, 0, 14'h0005, 0);
    rst = 1;
    cyc();
    chk("rst_gnt", {61'd0, s_gnt}, 64'd0);
    rst = 0;
    idle();
    cyc();
    chk("rst_mid_crv", {61'd0, s_crv}, 64'd0);
    chk("rst_mid_stall", {60'd0, s_stall}, 64'd0);
    for (int c = 0; c < 3; c++) chan(c, 0, 14'(32'h2001 + c), 0);
    cyc();
    chk("rst_rr", {61'd0, s_gnt}, 64'd1);
    idle();
    host(0, 14'h2222, 0);
    cyc();
    idle();
    cyc();
    chk("rst_word", {32'd0, s_hd}, 64'h77);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chan(0, 0, 14'h3001, 0);
      chan(1, 0, 14'h3002, 0);
      cyc();
    end
    idle();
    cyc();
    chk("sat15", {60'd0, s_stall}, 64'd15);
    cyc();
    chk("sat_hold", {60'd0, s_stall}, 64'd15);
    for (int i = 0; i < 16; i++) begin
      host(1, pool(i), $urandom);
      cyc();
    end
    idle();
    for (int n = 0; n < 1500; n++) begin
      rst = $urandom_range(0, 99) == 0;
      h_en = $urandom_range(0, 1) == 1;
      h_we = $urandom_range(0, 1) == 1;
      h_addr = pool($urandom_range(0, 15));
      h_din = $urandom;
      for (int c = 0; c < 3; c++)
        if (!(req[c] && !m_gnt[c])) begin
          req[c] = $urandom_range(0, 2) != 0;
          we[c] = $urandom_range(0, 1) == 1;
          addr[c] = pool($urandom_range(0, 15));
          din[c] = $urandom;
        end
      cyc();
    end
    rst = 0;
    idle();
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
